// File: rtl/ask_demodulator.sv
// ASK receiver: majority-votes the carrier activity in each bit window of a 1 + 5-bit frame.
// Optional `ASK_DEMOD_STOP_CHECK_EN adds a trailing no-carrier STOP window check before accepting.
module ask_demodulator #(
    parameter int THRESH   = 16,
    parameter int MIDLEVEL = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataIn,
    input  logic [2:0] cnt,
    input  logic       en,
    output logic [4:0] message,
    output logic       msgValid,
    output logic       busy,
    output logic       frameErr
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        DONE,
        STOP
    } state_t;

    localparam logic [8:0] ACT_HI = 9'(MIDLEVEL + THRESH);
    localparam logic [8:0] MID9   = 9'(MIDLEVEL);
    localparam logic [8:0] THR9   = 9'(THRESH);

    state_t     state;
    logic [8:0] t_lat;
    logic [7:0] win_cnt;
    logic [8:0] act_cnt;
    logic [2:0] bit_idx;
    logic [4:0] sh_reg;
    logic       err_pend;
`ifdef ASK_DEMOD_STOP_CHECK_EN
    logic [4:0] hold_reg;
`endif

    logic       act;
    logic [8:0] act_next;
    logic [8:0] t_sel;
    logic       win_end;
    logic       win_bit;

    // Window decision: carrier present for at least half of the T samples.
    function automatic logic majority(input logic [8:0] acts, input logic [8:0] t);
        return {acts, 1'b0} >= {1'b0, t};
    endfunction

    // Low-side test adds THRESH to the sample rather than subtracting it from the
    // midpoint, so no operand can wrap below zero.
    assign act      = ({1'b0, dataIn} >= ACT_HI) || (({1'b0, dataIn} + THR9) <= MID9);
    assign act_next = act_cnt + {8'd0, act};
    assign t_sel    = 9'd256 - {1'b0, cnt, 5'b00000};
    assign win_end  = ({1'b0, win_cnt} == (t_lat - 9'd1));
    assign win_bit  = majority(act_next, t_lat);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t_lat     <= 9'd0;
            win_cnt   <= 8'd0;
            act_cnt   <= 9'd0;
            bit_idx   <= 3'd0;
            err_pend  <= 1'b0;
            message   <= 5'd0;
            msgValid  <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            msgValid <= 1'b0;
            err_pend <= 1'b0;
            // A failed start window reports one cycle late so frameErr lands T clocks after the trigger.
            frameErr <= err_pend;
            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (act) begin
                            // Triggering sample is sample 0 of the start window.
                            t_lat   <= t_sel;
                            win_cnt <= 8'd1;
                            act_cnt <= 9'd1;
                            state   <= START;
                        end
                    end
                    START: begin
                        if (win_end) begin
                            win_cnt <= 8'd0;
                            act_cnt <= 9'd0;
                            if (win_bit) begin
                                bit_idx <= 3'd4;
                                state   <= DATA;
                            end else begin
                                err_pend <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            win_cnt <= win_cnt + 8'd1;
                            act_cnt <= act_next;
                        end
                    end
                    DATA: begin
                        if (win_end) begin
                            win_cnt <= 8'd0;
                            act_cnt <= 9'd0;
                            sh_reg  <= {sh_reg[3:0], win_bit};
                            if (bit_idx == 3'd0) begin
                                state <= DONE;
                            end else begin
                                bit_idx <= bit_idx - 3'd1;
                            end
                        end else begin
                            win_cnt <= win_cnt + 8'd1;
                            act_cnt <= act_next;
                        end
                    end
                    DONE: begin
`ifdef ASK_DEMOD_STOP_CHECK_EN
                        hold_reg <= sh_reg;
                        win_cnt  <= 8'd0;
                        act_cnt  <= 9'd0;
                        state    <= STOP;
`else
                        message  <= sh_reg;
                        msgValid <= 1'b1;
                        state    <= IDLE;
`endif
                    end
`ifdef ASK_DEMOD_STOP_CHECK_EN
                    STOP: begin
                        if (win_end) begin
                            win_cnt <= 8'd0;
                            act_cnt <= 9'd0;
                            if (!win_bit) begin
                                message  <= hold_reg;
                                msgValid <= 1'b1;
                            end else begin
                                frameErr <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            win_cnt <= win_cnt + 8'd1;
                            act_cnt <= act_next;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ask_demodulator.sv
// Directed bench for ask_demodulator: idle, frame decode at two rates, glitch, en abort, reset.
// Follows `ASK_DEMOD_STOP_CHECK_EN to pick the 6*T or 7*T acceptance latency.
module tb_ask_demodulator;

    logic       clk;
    logic       rst;
    logic [7:0] dataIn;
    logic [2:0] cnt;
    logic       en;
    logic [4:0] message;
    logic       msgValid;
    logic       busy;
    logic       frameErr;

    int checks   = 0;
    int failures = 0;

`ifdef ASK_DEMOD_STOP_CHECK_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    // Amplitude-100 sine at 8 samples/cycle, phase-shifted so no sample sits at 128.
    logic [7:0] sine [8] = '{8'd166, 8'd220, 8'd220, 8'd166, 8'd90, 8'd36, 8'd36, 8'd90};

    int   mv_cnt, fe_cnt, both_cnt, busy_cnt, mv_at, fe_at;
    logic busy_log [0:4095];

    ask_demodulator dut (
        .clk     (clk),
        .rst     (rst),
        .dataIn  (dataIn),
        .cnt     (cnt),
        .en      (en),
        .message (message),
        .msgValid(msgValid),
        .busy    (busy),
        .frameErr(frameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic step(input logic [7:0] s);
        dataIn = s;
        @(posedge clk);
        #1;
    endtask

    // Sample k is driven before clock edge k; observations after that edge are "cycle k".
    // glitch < 0: ASK frame 1+bits; glitch >= 0: that many 255 samples then 128.
    task automatic drive_frame(input logic [4:0] bits, input int t, input int len,
                               input int drop_at, input int rst_at, input int glitch);
        logic [7:0] s;
        int         w;
        logic       b;
        mv_cnt = 0; fe_cnt = 0; both_cnt = 0; busy_cnt = 0; mv_at = -1; fe_at = -1;
        for (int k = 0; k < len; k++) begin
            w = k / t;
            if (glitch >= 0) begin
                s = (k < glitch) ? 8'd255 : 8'd128;
            end else if (k < 6 * t) begin
                b = (w == 0) ? 1'b1 : bits[5 - w];
                s = b ? sine[k % 8] : 8'd128;
            end else begin
                s = 8'd128;
            end
            en  = !(drop_at >= 0 && k >= drop_at);
            rst = (k == rst_at);
            step(s);
            busy_log[k] = busy;
            if (busy) busy_cnt++;
            if (msgValid) begin mv_cnt++; mv_at = k; end
            if (frameErr) begin fe_cnt++; fe_at = k; end
            if (msgValid && frameErr) both_cnt++;
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt = 3'd0; dataIn = 8'd128;
        step(8'd128);
        step(8'd128);
        chk("rst_message", int'(message), 0);
        chk("rst_msgValid", int'(msgValid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frameErr", int'(frameErr), 0);
        rst = 1'b0;

        // Constant midlevel input
        cnt = 3'd7;
        drive_frame(5'b00000, 32, 2000, -1, -1, 0);
        chk("idle_mv", mv_cnt, 0);
        chk("idle_fe", fe_cnt, 0);
        chk("idle_busy", busy_cnt, 0);
        chk("idle_message", int'(message), 0);

        // T=32, frame 10110
        cnt = 3'd7;
        drive_frame(5'b10110, 32, LAT * 32 + 16, -1, -1, -1);
        chk("f1_mv_cnt", mv_cnt, 1);
        chk("f1_mv_at", mv_at, LAT * 32);
        chk("f1_message", int'(message), 22);
        chk("f1_fe", fe_cnt, 0);

        // T=256, frame 00001
        cnt = 3'd0;
        drive_frame(5'b00001, 256, LAT * 256 + 16, -1, -1, -1);
        chk("f2_mv_cnt", mv_cnt, 1);
        chk("f2_mv_at", mv_at, LAT * 256);
        chk("f2_message", int'(message), 1);

        // 5-sample glitch, T=32
        cnt = 3'd7;
        drive_frame(5'b00000, 32, 60, -1, -1, 5);
        chk("gl_fe_cnt", fe_cnt, 1);
        chk("gl_fe_at", fe_at, 32);
        chk("gl_mv", mv_cnt, 0);
        chk("gl_message", int'(message), 1);
        chk("gl_busy_end", int'(busy_log[59]), 0);

        // en dropped at clock 300 of a T=128 frame
        cnt = 3'd4;
        drive_frame(5'b11111, 128, 400, 300, -1, -1);
        chk("ab_busy_299", int'(busy_log[299]), 1);
        chk("ab_busy_301", int'(busy_log[301]), 0);
        chk("ab_mv", mv_cnt, 0);
        chk("ab_fe", fe_cnt, 0);
        chk("ab_message", int'(message), 1);
        drive_frame(5'b11111, 128, LAT * 128 + 16, -1, -1, -1);
        chk("f3_mv_at", mv_at, LAT * 128);
        chk("f3_message", int'(message), 31);

        // rst at clock 100 of a T=64 frame
        cnt = 3'd6;
        drive_frame(5'b11111, 64, 101, -1, 100, -1);
        chk("rs_message", int'(message), 0);
        chk("rs_busy", int'(busy), 0);
        chk("rs_msgValid", int'(msgValid), 0);
        chk("rs_frameErr", int'(frameErr), 0);
        drive_frame(5'b01010, 64, LAT * 64 + 16, -1, -1, -1);
        chk("f4_mv_at", mv_at, LAT * 64);
        chk("f4_message", int'(message), 10);
        chk("f4_both", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
